// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// The frame format is fixed at elaboration: CLK_DIV cycles per bit, DATA_BITS
// data bits sent LSB first, optional odd/even parity and one or two stop bits.
// Send is a level request. Frames stream back-to-back with no idle gap while it
// stays high.
// Optional feature: define UART_TX_CTS_EN to add an active-low nCTS input that
// gates acceptance of new frames. A frame already in flight always completes.
module uart_tx_frame #(
    parameter int CLK_DIV   = 347,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [8:0] TxData,
    input  logic       Send,
`ifdef UART_TX_CTS_EN
    input  logic       nCTS,
`endif
    output logic       Busy,
    output logic       Tx
);

    localparam int BAUD_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t                 state, stateNext;
    logic [BAUD_W-1:0]      baudCnt, baudNext;
    logic [3:0]             bitCnt, bitNext;
    logic [DATA_BITS-1:0]   shiftReg, shiftNext;
    logic                   parityReg, parityNext;
    logic                   txNext, busyNext;
    logic                   bitDone, lastData, lastStop;
    logic                   ctsOk, ctsBusy;
    logic                   parityCalc, startFrame;

    // Reject frame formats this transmitter cannot produce.
    generate
        if (CLK_DIV < 2) begin : gBadClkDiv
            $error("uart_tx_frame: CLK_DIV must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
            $error("uart_tx_frame: DATA_BITS must be within 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : gBadParity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStopBits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (DATA_BITS < 9) begin : gUnusedData
            logic [8-DATA_BITS:0] unusedTxData;
            assign unusedTxData = TxData[8:DATA_BITS];
        end
    endgenerate

`ifdef UART_TX_CTS_EN
    logic ctsMeta, ctsSync;

    // Two-flop synchroniser for the asynchronous nCTS pin. It is not reset, so
    // it keeps tracking the pin while Reset is asserted.
    always_ff @(posedge Clk) begin
        ctsMeta <= nCTS;
        ctsSync <= ctsMeta;
    end

    assign ctsOk   = ~ctsSync;
    assign ctsBusy = ctsMeta;
`else
    assign ctsOk   = 1'b1;
    assign ctsBusy = 1'b0;
`endif

    assign bitDone    = (baudCnt == '0);
    assign lastData   = (bitCnt == 4'(DATA_BITS - 1));
    assign lastStop   = (bitCnt == 4'(STOP_BITS - 1));
    assign parityCalc = (PARITY == 1) ? ~(^TxData[DATA_BITS-1:0]) : (^TxData[DATA_BITS-1:0]);
    assign startFrame = Send && !Busy && ctsOk &&
                        ((state == ST_IDLE) || (state == ST_STOP && bitDone && lastStop));

    // State and datapath registers. Reset parks the line idle, holds Busy and
    // abandons any frame in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            baudCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityReg <= 1'b0;
            Tx        <= 1'b1;
            Busy      <= 1'b1;
        end else begin
            state     <= stateNext;
            baudCnt   <= baudNext;
            bitCnt    <= bitNext;
            shiftReg  <= shiftNext;
            parityReg <= parityNext;
            Tx        <= txNext;
            Busy      <= busyNext;
        end
    end

    // Frame sequencing. Each bit period ends when the baud counter reaches zero.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (startFrame) stateNext = ST_START;
            ST_START:  if (bitDone) stateNext = ST_DATA;
            ST_DATA:   if (bitDone && lastData) stateNext = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bitDone) stateNext = ST_STOP;
            ST_STOP:   if (bitDone && lastStop) stateNext = startFrame ? ST_START : ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // Next-cycle values for the line, the Busy flag, the counters and the
    // shifter. Busy drops one cycle before the last stop bit ends, so a
    // back-to-back frame can start right after it.
    always_comb begin
        baudNext   = baudCnt;
        bitNext    = bitCnt;
        shiftNext  = shiftReg;
        parityNext = parityReg;
        txNext     = Tx;
        busyNext   = Busy;
        if (state != ST_IDLE && !bitDone) begin
            baudNext = baudCnt - 1'b1;
        end
        case (state)
            ST_IDLE: begin
                txNext   = 1'b1;
                busyNext = ctsBusy;
            end
            ST_START: begin
                if (bitDone) begin
                    txNext    = shiftReg[0];
                    shiftNext = shiftReg >> 1;
                    bitNext   = '0;
                    baudNext  = BAUD_LOAD;
                end
            end
            ST_DATA: begin
                if (bitDone) begin
                    baudNext = BAUD_LOAD;
                    if (lastData) begin
                        txNext  = (PARITY != 0) ? parityReg : 1'b1;
                        bitNext = '0;
                    end else begin
                        txNext    = shiftReg[0];
                        shiftNext = shiftReg >> 1;
                        bitNext   = bitCnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bitDone) begin
                    txNext   = 1'b1;
                    bitNext  = '0;
                    baudNext = BAUD_LOAD;
                end
            end
            ST_STOP: begin
                if (bitDone) begin
                    txNext = 1'b1;
                    if (lastStop) begin
                        busyNext = ctsBusy;
                        bitNext  = '0;
                    end else begin
                        bitNext  = bitCnt + 4'd1;
                        baudNext = BAUD_LOAD;
                    end
                end else if (lastStop && baudCnt == BAUD_W'(1)) begin
                    busyNext = 1'b0;
                end
            end
            default: begin
                txNext   = 1'b1;
                busyNext = 1'b1;
            end
        endcase
        if (startFrame) begin
            shiftNext  = TxData[DATA_BITS-1:0];
            parityNext = parityCalc;
            txNext     = 1'b0;
            busyNext   = 1'b1;
            baudNext   = BAUD_LOAD;
            bitNext    = '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame.
// Three instances cover 8N1 (CLK_DIV=4), 7E2 (CLK_DIV=3) and 9O1 (CLK_DIV=3).
// Stimulus queues the hand-computed bit sequence it expects on the line. A
// monitor waits for a start bit, pops that entry and checks every cycle of
// the frame, the Busy profile and, for chained frames, the frame pitch.
module tb_uart_tx_frame;

    typedef struct {
        int         dut;
        logic [12:0] bits;
        int         nBits;
        int         clkDiv;
        bit         chained;
    } expEntry;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       sendW [3];
    logic [8:0] dataW [3];
    logic       txW   [3];
    logic       busyW [3];
    logic       monEnable = 1'b0;
    logic       inFrame = 1'b0;
    int         divOf [3] = '{4, 3, 3};
    int         compared = 0;
    int         mismatched = 0;
    int         cycleCnt = 0;
    int         lastStart = 0;
    expEntry    expQ [$];

`ifdef UART_TX_CTS_EN
    logic nCts = 1'b0;
`endif

    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8n1 (
        .Clk(Clk), .Reset(Reset), .TxData(dataW[0]), .Send(sendW[0]),
`ifdef UART_TX_CTS_EN
        .nCTS(nCts),
`endif
        .Busy(busyW[0]), .Tx(txW[0]));

    uart_tx_frame #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7e2 (
        .Clk(Clk), .Reset(Reset), .TxData(dataW[1]), .Send(sendW[1]),
`ifdef UART_TX_CTS_EN
        .nCTS(nCts),
`endif
        .Busy(busyW[1]), .Tx(txW[1]));

    uart_tx_frame #(.CLK_DIV(3), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) dut9o1 (
        .Clk(Clk), .Reset(Reset), .TxData(dataW[2]), .Send(sendW[2]),
`ifdef UART_TX_CTS_EN
        .nCTS(nCts),
`endif
        .Busy(busyW[2]), .Tx(txW[2]));

    // Free-running clock plus an edge counter used to measure frame pitch.
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycleCnt <= cycleCnt + 1;

    // Hard stop in case the run ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required to have finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic pushExpected(input int d, input string seq, input bit chained);
        expEntry e;
        e.dut = d;
        e.bits = '0;
        for (int i = 0; i < seq.len(); i++) e.bits[i] = (seq[i] == "1");
        e.nBits = seq.len();
        e.clkDiv = divOf[d];
        e.chained = chained;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int d, input logic [8:0] data, input string seq);
        pushExpected(d, seq, 1'b0);
        @(negedge Clk);
        dataW[d] = data;
        sendW[d] = 1'b1;
        @(posedge Clk);
        #1 sendW[d] = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || inFrame) && n < budget) begin
            @(posedge Clk);
            n++;
        end
        checkOutput("frames_pending_after_wait", expQ.size() + int'(inFrame), 0);
        expQ.delete();
        repeat (3) @(posedge Clk);
    endtask

    // Monitor: a low line outside a frame is a start bit. Check it against the
    // oldest queued expectation, one comparison per transmitted bit.
    initial begin : monitorProc
        int      d;
        int      k;
        int      busyHigh;
        int      lastBusy;
        int      badSample;
        logic    expBit;
        expEntry e;
        forever begin
            @(negedge Clk);
            if (monEnable && !Reset) begin
                d = -1;
                for (int i = 2; i >= 0; i--) if (txW[i] == 1'b0) d = i;
                if (d >= 0 && expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_start: dut %0d line got 0, required idle 1", d);
                    for (int w = 0; w < 64 && txW[d] == 1'b0; w++) @(negedge Clk);
                end else if (d >= 0) begin
                    e = expQ.pop_front();
                    inFrame = 1'b1;
                    checkOutput("frame_dut", d, e.dut);
                    if (e.chained) checkOutput("frame_pitch", cycleCnt - lastStart, e.nBits * e.clkDiv);
                    lastStart = cycleCnt;
                    busyHigh = 0;
                    lastBusy = 0;
                    k = 0;
                    for (int b = 0; b < e.nBits; b++) begin
                        expBit = e.bits[b];
                        badSample = int'(expBit);
                        for (int c = 0; c < e.clkDiv; c++) begin
                            if (k != 0) @(negedge Clk);
                            if (txW[d] !== expBit) badSample = int'(txW[d]);
                            if (busyW[d] === 1'b1) busyHigh++;
                            lastBusy = int'(busyW[d]);
                            k++;
                        end
                        checkOutput($sformatf("tx_bit%0d_dut%0d", b, d), badSample, int'(expBit));
                    end
                    checkOutput($sformatf("busy_high_cycles_dut%0d", d), busyHigh, e.nBits * e.clkDiv - 1);
                    checkOutput($sformatf("busy_last_cycle_dut%0d", d), lastBusy, 0);
                    inFrame = 1'b0;
                end
            end
        end
    end

    // Directed sequence: reset, single frames per format, ignored Send while
    // busy, back-to-back streaming and a reset that aborts a frame.
    initial begin
        for (int i = 0; i < 3; i++) begin
            sendW[i] = 1'b0;
            dataW[i] = '0;
        end

        repeat (3) @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_tx_dut%0d", i), int'(txW[i]), 1);
            checkOutput($sformatf("reset_busy_dut%0d", i), int'(busyW[i]), 1);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("release_busy_dut%0d", i), int'(busyW[i]), 0);
            checkOutput($sformatf("release_tx_dut%0d", i), int'(txW[i]), 1);
        end
        monEnable = 1'b1;

        $display("[TB] 8N1 frame 0x0A5");
        applyStimulus(0, 9'h0A5, "0101001011");
        waitIdle(200);

        $display("[TB] 8N1 frame 0x13A, upper bit ignored, Send while busy ignored");
        applyStimulus(0, 9'h13A, "0010111001");
        repeat (10) @(negedge Clk);
        dataW[0] = 9'h0FF;
        sendW[0] = 1'b1;
        @(posedge Clk);
        #1 sendW[0] = 1'b0;
        waitIdle(200);
        repeat (20) @(posedge Clk);

        $display("[TB] 7E2 frames 0x07 and 0x55");
        applyStimulus(1, 9'h007, "01110000111");
        waitIdle(200);
        applyStimulus(1, 9'h055, "01010101011");
        waitIdle(200);

        $display("[TB] 9O1 back-to-back 0x1FF then 0x000");
        pushExpected(2, "011111111101", 1'b0);
        pushExpected(2, "000000000011", 1'b1);
        @(negedge Clk);
        dataW[2] = 9'h1FF;
        sendW[2] = 1'b1;
        @(posedge Clk);
        #1 dataW[2] = 9'h000;
        repeat (36) @(posedge Clk);
        #1 sendW[2] = 1'b0;
        waitIdle(200);

        $display("[TB] reset during data bit 3");
        monEnable = 1'b0;
        @(negedge Clk);
        dataW[0] = 9'h000;
        sendW[0] = 1'b1;
        @(posedge Clk);
        #1 sendW[0] = 1'b0;
        repeat (17) @(posedge Clk);
        #1;
        checkOutput("abort_tx_in_bit3", int'(txW[0]), 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("abort_tx_after_reset", int'(txW[0]), 1);
        checkOutput("abort_busy_after_reset", int'(busyW[0]), 1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("abort_release_busy", int'(busyW[0]), 0);
        repeat (10) @(posedge Clk);
        #1;
        checkOutput("abort_line_idle", int'(txW[0]), 1);
        monEnable = 1'b1;
        applyStimulus(0, 9'h05C, "0001110101");
        waitIdle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
